// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PCF, IF/ID register, valid/ready imem port.
// Define FETCH_PERF_CNT_EN to add the bubble and redirect counters.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_stall_cnt,
    output logic [31:0]     redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     hold_q, hold_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;
    logic            valid_q, valid_d;
    logic            hs;
    logic            deliver;
    logic [31:0]     dlv_instr;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4       = pc_q + XLEN'(4);
    assign imem_req_valid = rst_n & (state_q == S_FETCH);
    assign imem_req_addr  = pc_q;
    assign hs             = imem_req_valid & imem_req_ready;

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_d    = hold_q;
        instr_d   = instr_q;
        pcd_d     = pcd_q;
        pcp4_d    = pcp4_q;
        valid_d   = valid_q;
        deliver   = 1'b0;
        dlv_instr = hold_q;
        if (PCSrcE) begin
            // Redirect wins over stall; an accepted request must still drain.
            pc_d    = PCTargetE & ~XLEN'(3);
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            unique case (state_q)
                S_FETCH: state_d = hs ? S_DRAIN : S_FETCH;
                S_WAIT:  state_d = imem_rsp_valid ? S_FETCH : S_DRAIN;
                S_HOLD:  state_d = S_FETCH;
                S_DRAIN: state_d = imem_rsp_valid ? S_FETCH : S_DRAIN;
                default: state_d = S_FETCH;
            endcase
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (hs) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (StallD) begin
                            hold_d  = imem_rsp_data;
                            state_d = S_HOLD;
                        end else begin
                            deliver   = 1'b1;
                            dlv_instr = imem_rsp_data;
                            state_d   = S_FETCH;
                        end
                    end
                end
                S_HOLD: begin
                    if (!StallD) begin
                        deliver = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_rsp_valid) state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
            if (deliver) begin
                instr_d = dlv_instr;
                pcd_d   = pc_q;
                pcp4_d  = pc_plus4;
                valid_d = 1'b1;
                pc_d    = pc_plus4;
            end else if (!StallD) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] redir_cnt_q;
    logic        bubble;

    assign bubble = ~PCSrcE & ~StallD & ~deliver;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (bubble && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (PCSrcE && (redir_cnt_q != '1))
                redir_cnt_q <= redir_cnt_q + 32'd1;
        end
    end

    assign fetch_stall_cnt = stall_cnt_q;
    assign redirect_cnt    = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner sequences,
// and random traffic against a transaction-level fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_stall_cnt;
    logic [31:0] redirect_cnt;
`endif

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .StallD         (StallD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_stall_cnt(fetch_stall_cnt),
        .redirect_cnt   (redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding fetch, an optional parked word,
    // and the instruction currently presented to decode.
    logic [31:0] m_pc;
    bit          m_infl;
    bit          m_drop;
    bit          m_hv;
    logic [31:0] m_hbuf;
    bit          m_vd;
    logic [31:0] m_instr, m_pcd, m_pcp4;
    int unsigned m_bub_cnt, m_red_cnt;

    task automatic model_reset();
        m_pc = 32'h0; m_infl = 0; m_drop = 0; m_hv = 0; m_hbuf = '0;
        m_vd = 0; m_instr = NOP; m_pcd = '0; m_pcp4 = '0;
        m_bub_cnt = 0; m_red_cnt = 0;
    endtask

    task automatic model_step(input bit st, input bit rd,
                              input logic [31:0] tg, input bit rdy,
                              input bit rsp, input logic [31:0] data);
        bit rv, hs, got, dv;
        logic [31:0] di;
        rv = !m_infl && !m_hv;
        hs = rv && rdy;
        got = m_infl && rsp;
        dv = 0;
        di = '0;
        if (rd) begin
            m_red_cnt++;
            m_pc = {tg[31:2], 2'b00};
            m_instr = NOP; m_vd = 0; m_hv = 0;
            if (hs) begin
                m_infl = 1; m_drop = 1;
            end else if (m_infl && !got) begin
                m_drop = 1;
            end else begin
                m_infl = 0; m_drop = 0;
            end
        end else begin
            if (m_hv && !st) begin
                dv = 1; di = m_hbuf; m_hv = 0;
            end else if (got && !m_drop && !st) begin
                dv = 1; di = data;
            end else if (got && !m_drop) begin
                m_hv = 1; m_hbuf = data;
            end
            if (got) begin m_infl = 0; m_drop = 0; end
            if (hs) m_infl = 1;
            if (dv) begin
                m_instr = di; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4;
                m_vd = 1; m_pc = m_pc + 32'd4;
            end else if (!st) begin
                m_instr = NOP; m_vd = 0; m_bub_cnt++;
            end
        end
    endtask

    // Memory: answers each accepted request after lat_lo..lat_hi idle cycles.
    bit          mem_pend;
    int          mem_dly;
    logic [31:0] mem_data;
    int          lat_lo, lat_hi;
    bit          rand_data;
    logic [31:0] imem [logic [31:0]];
    logic        snap_rv;
    logic [31:0] snap_addr;

    task automatic cycle(input bit st, input bit rd, input logic [31:0] tg,
                         input bit rdy, input bit spur);
        bit rsp_now, hs_dut, exp_rv;
        logic [31:0] a;
        StallD = st; PCSrcE = rd; PCTargetE = tg; imem_req_ready = rdy;
        rsp_now = mem_pend && (mem_dly == 0);
        imem_rsp_valid = rsp_now || (spur && !mem_pend);
        imem_rsp_data = rsp_now ? mem_data : 32'hDEAD_BEEF;
        #1;
        exp_rv = !m_infl && !m_hv;
        snap_rv = imem_req_valid;
        snap_addr = imem_req_addr;
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        hs_dut = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        model_step(st, rd, tg, rdy, imem_rsp_valid, imem_rsp_data);
        @(posedge clk);
        #1;
        if (rsp_now) mem_pend = 0;
        else if (mem_pend) mem_dly--;
        if (hs_dut) begin
            mem_pend = 1;
            mem_dly = $urandom_range(lat_hi, lat_lo);
            if (imem.exists(a)) mem_data = imem[a];
            else mem_data = rand_data ? $urandom : a;
        end
        chk("ValidD", ValidD, m_vd);
        chk("InstrD", InstrD, m_instr);
        if (m_vd) begin
            chk("PCD", PCD, m_pcd);
            chk("PCPlus4D", PCPlus4D, m_pcp4);
        end
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
        chk({tag, "_InstrD"}, InstrD, NOP);
        chk({tag, "_ValidD"}, ValidD, 1'b0);
        chk({tag, "_PCD"}, PCD, 32'h0);
        chk({tag, "_PCPlus4D"}, PCPlus4D, 32'h0);
    endtask

    typedef struct {
        bit          st;
        bit          rd;
        logic [31:0] tg;
        bit          rdy;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_vd;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back(vec_t'{0, 0, 0, 1, 1, 32'h0,  0, NOP});
        tbl.push_back(vec_t'{0, 0, 0, 1, 0, 32'h0,  1, 32'h0});
        for (int i = 0; i < 4; i++)
            tbl.push_back(vec_t'{0, 0, 0, 0, 1, 32'h4, 0, NOP});
        tbl.push_back(vec_t'{0, 0, 0, 1, 1, 32'h4,  0, NOP});
        tbl.push_back(vec_t'{0, 0, 0, 1, 0, 32'h0,  1, 32'h4});
        tbl.push_back(vec_t'{0, 0, 0, 1, 1, 32'h8,  0, NOP});
        tbl.push_back(vec_t'{0, 0, 0, 1, 0, 32'h0,  1, 32'h8});
        tbl.push_back(vec_t'{1, 0, 0, 1, 1, 32'hC,  1, 32'h8});
        tbl.push_back(vec_t'{1, 0, 0, 1, 0, 32'h0,  1, 32'h8});
        tbl.push_back(vec_t'{1, 0, 0, 1, 0, 32'h0,  1, 32'h8});
        tbl.push_back(vec_t'{0, 0, 0, 1, 0, 32'h0,  1, 32'h0050_0093});
        tbl.push_back(vec_t'{0, 0, 0, 1, 1, 32'h10, 0, NOP});
        tbl.push_back(vec_t'{0, 0, 0, 1, 0, 32'h0,  1, 32'h10});

        imem[32'hC] = 32'h0050_0093;
        lat_lo = 0; lat_hi = 0; rand_data = 0;
        mem_pend = 0; mem_dly = 0; mem_data = '0;
        StallD = 0; PCSrcE = 0; PCTargetE = '0;
        imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = '0;
        rst_n = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1;

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].st, tbl[i].rd, tbl[i].tg, tbl[i].rdy, 0);
            chk($sformatf("tbl%0d_req_valid", i), snap_rv, tbl[i].e_rv);
            if (tbl[i].e_rv)
                chk($sformatf("tbl%0d_req_addr", i), snap_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_ValidD", i), ValidD, tbl[i].e_vd);
            chk($sformatf("tbl%0d_InstrD", i), InstrD, tbl[i].e_instr);
        end

        // Redirect while waiting on a slow response.
        lat_lo = 2; lat_hi = 2;
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 32'h103, 1, 0);
        chk("redir_wait_ValidD", ValidD, 1'b0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        chk("redir_wait_drop", InstrD, NOP);
        chk("redir_wait_req", imem_req_valid, 1'b1);
        chk("redir_wait_addr", imem_req_addr, 32'h100);

        // Redirect colliding with a response under stall.
        lat_lo = 0; lat_hi = 0;
        cycle(0, 0, 0, 1, 0);
        cycle(1, 1, 32'h200, 1, 0);
        chk("redir_rsp_ValidD", ValidD, 1'b0);
        chk("redir_rsp_addr", imem_req_addr, 32'h200);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        chk("redir_rsp_instr", InstrD, 32'h200);

        // PC wrap-around.
        cycle(0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        chk("wrap_PCD", PCD, 32'hFFFF_FFFC);
        chk("wrap_PCPlus4D", PCPlus4D, 32'h0);
        chk("wrap_next_addr", imem_req_addr, 32'h0);

        // Reset in the middle of an outstanding fetch; late response ignored.
        cycle(0, 0, 0, 1, 0);
        rst_n = 0;
        #1;
        chk_reset("midrst");
        imem_rsp_valid = 1;
        imem_rsp_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        rst_n = 1;
        mem_pend = 0;
        model_reset();
        cycle(0, 0, 0, 1, 1);
        chk("late_rsp_ValidD", ValidD, 1'b0);
        cycle(0, 0, 0, 1, 0);
        chk("after_rst_ValidD", ValidD, 1'b1);
        chk("after_rst_InstrD", InstrD, 32'h0);

        // Random traffic.
        lat_lo = 0; lat_hi = 2; rand_data = 1;
        for (int n = 0; n < 3000; n++) begin
            bit st, rd, rdy, sp;
            logic [31:0] tg;
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 15) == 0);
            tg = $urandom;
            if ($urandom_range(0, 3) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'hF);
            rdy = ($urandom_range(0, 9) < 7);
            sp = ($urandom_range(0, 19) == 0);
            cycle(st, rd, tg, rdy, sp);
        end

`ifdef FETCH_PERF_CNT_EN
        chk("fetch_stall_cnt", fetch_stall_cnt, m_bub_cnt);
        chk("redirect_cnt", redirect_cnt, m_red_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RV32I core.
- Owns PCF and the IF/ID pipeline register, and drives a valid/ready instruction-memory port (at most one request outstanding).
- Consumes the branch/jump redirect (PCSrcE, PCTargetE) that the decode-stage controller resolves in EX. Consumes StallD from the hazard unit.
- Feeds InstrD to the controller and datapath.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- StallD  input  1  hold IF/ID and PCF (load-use stall).
- PCSrcE  input  1  redirect request from EX (Branch&Zero | Jump).
- PCTargetE  input  XLEN  redirect target.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  XLEN  request address, always PCF.
- imem_rsp_valid  input  1  response data valid, single-cycle pulse.
- imem_rsp_data  input  32  fetched instruction.
- InstrD  output  32  IF/ID instruction.
- PCD  output  XLEN  IF/ID PC.
- PCPlus4D  output  XLEN  IF/ID PC+4.
- ValidD  output  1  InstrD is a real instruction.

Behaviour:
- **Reset (async, rst_n=0):**
  - PCF=RESET_PC, state=FETCH, hold buffer empty.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - imem_req_valid=0 while rst_n=0.
- **State FETCH:**
  - imem_req_valid=1, imem_req_addr=PCF.
  - Request handshake (valid & ready) -> WAIT.
- **State WAIT:**
  - imem_req_valid=0; awaiting imem_rsp_valid.
  - On response with StallD=0: InstrD<=rsp_data, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1, PCF<=PCF+4 -> FETCH.
  - On response with StallD=1: capture data into the 1-entry hold buffer -> HOLD.
- **State HOLD:**
  - imem_req_valid=0.
  - When StallD=0: transfer buffer to IF/ID (same fields as above), PCF<=PCF+4 -> FETCH.
- **State DRAIN:**
  - imem_req_valid=0.
  - Discard the next response; no IF/ID load -> FETCH.
- **StallD=1:**
  - InstrD/PCD/PCPlus4D/ValidD hold.
  - PCF holds.
  - An outstanding request still completes into HOLD.
- **Bubble:** StallD=0 and no instruction delivered this cycle -> InstrD<=NOP_INSTR, ValidD<=0 (PCD/PCPlus4D don't-care, held).
- **Redirect (PCSrcE=1)** has highest priority, overriding StallD:
  - PCF<=PCTargetE with bits [1:0] forced to 0.
  - IF/ID flushed: InstrD<=NOP_INSTR, ValidD<=0.
  - FETCH with handshake this cycle -> DRAIN; FETCH without handshake -> FETCH.
  - WAIT with response this cycle -> response dropped -> FETCH.
  - WAIT without response -> DRAIN.
  - HOLD -> buffer cleared -> FETCH.
  - DRAIN -> stays DRAIN, or FETCH if the response arrives this cycle.
- **Latency:** minimum 2 cycles per instruction (request cycle + response cycle). A zero-wait memory returns the response in the cycle after acceptance.
- **PC arithmetic:** PCF+4 wraps modulo 2^XLEN; no exception.
- imem_rsp_valid outside WAIT/DRAIN is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- **Defined:**
  - Adds outputs fetch_stall_cnt (32) and redirect_cnt (32).
  - fetch_stall_cnt counts cycles with StallD=0 and ValidD loaded 0 (front-end bubbles, excluding redirect flushes).
  - redirect_cnt counts cycles with PCSrcE=1.
  - Both are reset to 0 by rst_n and saturate at 32'hFFFF_FFFF.
- **Undefined:** ports and counters absent; behaviour otherwise identical.

Test Plan:
- **Reset/sequential:** rst_n low 3 cycles, release; memory ready always, 1-cycle response with data = addr -> requests at 0x0,0x4,0x8; ValidD rises 2 cycles after release with InstrD=0x0, PCD=0x0, PCPlus4D=0x4.
- **Back-pressure:** imem_req_ready low for 4 cycles -> imem_req_addr stays 0x4, ValidD=0 bubbles (InstrD=0x13), no duplicate request accepted.
- **Stall:** StallD=1 for 3 cycles while response 0x00500093 arrives -> InstrD holds previous value. On release, InstrD=0x00500093 next edge; PCF advances exactly once.
- **Redirect while WAIT:** PCSrcE=1, PCTargetE=0x103 -> ValidD=0 next cycle; the in-flight response is discarded; next request addr=0x100.
- **Redirect with simultaneous response/stall:** PCSrcE=1 same cycle as imem_rsp_valid and StallD=1 -> IF/ID flushed (ValidD=0), next request addr=target.
- **Wrap and mid-operation reset:** PCF=0xFFFF_FFFC fetch -> PCPlus4D=0x0, next addr 0x0. Then assert rst_n low in WAIT -> outputs return to reset values immediately; a late response is ignored.
